layer_sequencer: RTL and testbench

Parametrised successor to the fixed conv/pool/connect controller. Sequences NUM_STAGES compute stages in index order. Per-frame stage bypass, a frame-count loop mode, and a valid/ready result handshake replace the free-running FIN state. A per-stage watchdog traps hung stages. Sits at the top of the accelerator, driving each stage's enable and collecting each stage's finish.

---
 rtl/ls_pkg.sv | 21 ++
 rtl/stage_watchdog.sv | 27 ++
 rtl/layer_sequencer.sv | 136 +++++++++++++
 tb/tb_layer_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// ls_pkg: shared state encoding and stage-index helpers for layer_sequencer
package ls_pkg;

    typedef enum logic [2:0] {IDLE, RUN, OUT, DONE, ERR} state_t;

    localparam int MAX_S = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // lowest non-skipped index at or above from; n when none is left
    function automatic int next_stage(input logic [MAX_S-1:0] skip, input int from, input int n);
        int r;
        r = n;
        for (int k = MAX_S - 1; k >= 0; k--)
            if (k >= from && k < n && !skip[k]) r = k;
        return r;
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: cycle counter that pulses fire when a stage overruns its limit
module stage_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             fin,
    input  logic [TMO_W-1:0] limit,
    output logic             fire
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    // clear wins over counting so every stage entry starts from zero
    always_comb cnt_d = clr ? '0 : en ? cnt_q + TMO_W'(1) : cnt_q;

    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    // a finish in the last allowed cycle beats the timeout
    assign fire = en && !fin && (limit != '0) && (cnt_q == limit - TMO_W'(1));

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs stages in index order with bypass, frame looping, result handshake and watchdog
module layer_sequencer
    import ls_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int FRAME_W    = 8,
    parameter int TMO_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            calc_en,
    input  logic [FRAME_W-1:0]              frame_num,
    input  logic [NUM_STAGES-1:0]           stage_skip,
    input  logic [TMO_W-1:0]                tmo_limit,
    input  logic [NUM_STAGES-1:0]           stage_fin,
    input  logic                            out_ready,
    output logic [NUM_STAGES-1:0]           stage_en,
    output logic                            out_data_flag,
    output logic                            busy,
    output logic                            done,
    output logic                            tmo_err,
    output logic [idx_w(NUM_STAGES)-1:0]    err_stage,
    output logic [FRAME_W-1:0]              frame_cnt
);

    localparam int IDX_W = idx_w(NUM_STAGES);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, err_stage_q, err_stage_d;
    logic [NUM_STAGES-1:0] skip_q, skip_d, stage_en_q, stage_en_d;
    logic [FRAME_W-1:0]    fnum_q, fnum_d, frame_cnt_q, frame_cnt_d, cnt_inc;
    logic                  out_flag_q, out_flag_d, busy_q, busy_d, done_q, done_d, tmo_q, tmo_d;
    logic                  fin_hit, wd_fire;
    int                    nxt;

    // only the active stage's finish counts; stage_en_q is zero outside RUN
    assign fin_hit = |(stage_en_q & stage_fin);
    assign cnt_inc = frame_cnt_q + FRAME_W'(1);

    stage_watchdog #(.TMO_W(TMO_W)) u_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q != RUN) || fin_hit),
        .en    (state_q == RUN),
        .fin   (fin_hit),
        .limit (tmo_limit),
        .fire  (wd_fire)
    );

    // next state plus registered-output images of that next state
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        skip_d      = skip_q;
        fnum_d      = fnum_q;
        frame_cnt_d = frame_cnt_q;
        err_stage_d = err_stage_q;
        nxt         = 0;
        case (state_q)
            IDLE: if (calc_en) begin
                skip_d      = stage_skip;
                fnum_d      = frame_num;
                frame_cnt_d = '0;
                nxt         = next_stage(MAX_S'(stage_skip), 0, NUM_STAGES);
                state_d     = (nxt == NUM_STAGES) ? OUT : RUN;
                idx_d       = IDX_W'(nxt);
            end
            RUN: if (!calc_en) begin
                state_d     = IDLE;
                frame_cnt_d = '0;
            end else if (fin_hit) begin
                nxt     = next_stage(MAX_S'(skip_q), int'(idx_q) + 1, NUM_STAGES);
                state_d = (nxt == NUM_STAGES) ? OUT : RUN;
                idx_d   = IDX_W'(nxt);
            end else if (wd_fire) begin
                state_d     = ERR;
                err_stage_d = idx_q;
            end
            OUT: if (out_ready) begin
                frame_cnt_d = cnt_inc;
                if (fnum_q != '0 && cnt_inc == fnum_q) state_d = DONE;
                else if (calc_en) begin
                    skip_d  = stage_skip;
                    nxt     = next_stage(MAX_S'(stage_skip), 0, NUM_STAGES);
                    state_d = (nxt == NUM_STAGES) ? OUT : RUN;
                    idx_d   = IDX_W'(nxt);
                end else state_d = IDLE;
            end
            DONE, ERR: if (!calc_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        stage_en_d = '0;
        for (int k = 0; k < NUM_STAGES; k++) stage_en_d[k] = (state_d == RUN) && (int'(idx_d) == k);
        out_flag_d = (state_d == OUT);
        busy_d     = (state_d == RUN) || (state_d == OUT);
        done_d     = (state_d == DONE);
        tmo_d      = (state_d == ERR);
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            skip_q      <= '0;
            fnum_q      <= '0;
            frame_cnt_q <= '0;
            err_stage_q <= '0;
            stage_en_q  <= '0;
            out_flag_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            skip_q      <= skip_d;
            fnum_q      <= fnum_d;
            frame_cnt_q <= frame_cnt_d;
            err_stage_q <= err_stage_d;
            stage_en_q  <= stage_en_d;
            out_flag_q  <= out_flag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
        end

    assign stage_en      = stage_en_q;
    assign out_data_flag = out_flag_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign tmo_err       = tmo_q;
    assign err_stage     = err_stage_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed checks of sequencing, bypass, handshake, watchdog, abort and reset
module tb_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       calc_en = 1'b0;
    logic [7:0] frame_num = '0;
    logic [2:0] stage_skip = '0;
    logic [15:0] tmo_limit = '0;
    logic [2:0] stage_fin = '0;
    logic       out_ready = 1'b0;
    logic [2:0] stage_en;
    logic       out_data_flag, busy, done, tmo_err;
    logic [1:0] err_stage;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    layer_sequencer #(.NUM_STAGES(3), .FRAME_W(8), .TMO_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .calc_en       (calc_en),
        .frame_num     (frame_num),
        .stage_skip    (stage_skip),
        .tmo_limit     (tmo_limit),
        .stage_fin     (stage_fin),
        .out_ready     (out_ready),
        .stage_en      (stage_en),
        .out_data_flag (out_data_flag),
        .busy          (busy),
        .done          (done),
        .tmo_err       (tmo_err),
        .err_stage     (err_stage),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_en"},   32'(stage_en), 0);
        check({tag, "_flag"}, 32'(out_data_flag), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_tmo"},  32'(tmo_err), 0);
        check({tag, "_errs"}, 32'(err_stage), 0);
        check({tag, "_fcnt"}, 32'(frame_cnt), 0);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // wait w cycles, then pulse fin of stage k for one cycle
    task automatic fin_stage(input int k, input int w);
        repeat (w) cyc();
        stage_fin = 3'(1 << k);
        cyc();
        stage_fin = '0;
    endtask

    initial begin
        cyc();
        check_zero("reset");
        rst_n = 1'b1;
        cyc();
        // single frame, no bypass
        frame_num = 8'd1;
        calc_en   = 1'b1;
        cyc();
        check("t1_en0", 32'(stage_en), 32'b001);
        check("t1_busy", 32'(busy), 1);
        fin_stage(0, 4);
        check("t1_en1", 32'(stage_en), 32'b010);
        stage_fin = 3'b101;
        cyc();
        stage_fin = '0;
        check("t1_ignore_other_fin", 32'(stage_en), 32'b010);
        fin_stage(1, 3);
        check("t1_en2", 32'(stage_en), 32'b100);
        fin_stage(2, 4);
        check("t1_flag", 32'(out_data_flag), 1);
        check("t1_en_off", 32'(stage_en), 0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("t1_done", 32'(done), 1);
        check("t1_fcnt", 32'(frame_cnt), 1);
        check("t1_flag_drop", 32'(out_data_flag), 0);
        check("t1_busy_off", 32'(busy), 0);
        calc_en = 1'b0;
        cyc();
        check("t1_idle_done", 32'(done), 0);
        // two frames, stage 1 bypassed; mid-frame skip change ignored
        frame_num  = 8'd2;
        stage_skip = 3'b010;
        calc_en    = 1'b1;
        cyc();
        check("t2_en0", 32'(stage_en), 32'b001);
        check("t2_fcnt_clr", 32'(frame_cnt), 0);
        stage_skip = 3'b000;
        fin_stage(0, 2);
        check("t2_skip1", 32'(stage_en), 32'b100);
        fin_stage(2, 2);
        check("t2_flag", 32'(out_data_flag), 1);
        stage_skip = 3'b010;
        out_ready  = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("t2_rerun", 32'(stage_en), 32'b001);
        check("t2_fcnt1", 32'(frame_cnt), 1);
        check("t2_flag_drop", 32'(out_data_flag), 0);
        fin_stage(0, 1);
        check("t2_skip1b", 32'(stage_en), 32'b100);
        fin_stage(2, 1);
        check("t2_flag2", 32'(out_data_flag), 1);
        // backpressure with calc_en toggling
        for (int i = 0; i < 10; i++) begin
            calc_en = ~calc_en;
            cyc();
            check("t3_hold_flag", 32'(out_data_flag), 1);
            check("t3_hold_fcnt", 32'(frame_cnt), 1);
            check("t3_hold_en", 32'(stage_en), 0);
        end
        calc_en   = 1'b1;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("t3_done", 32'(done), 1);
        check("t3_fcnt2", 32'(frame_cnt), 2);
        check("t3_flag_drop", 32'(out_data_flag), 0);
        cyc();
        check("t3_done_hold", 32'(done), 1);
        check("t3_fcnt_hold", 32'(frame_cnt), 2);
        calc_en = 1'b0;
        cyc();
        check("t3_idle", 32'(done), 0);
        check("t3_idle_fcnt", 32'(frame_cnt), 2);
        // every stage bypassed goes straight to OUT
        frame_num  = 8'd1;
        stage_skip = 3'b111;
        calc_en    = 1'b1;
        cyc();
        check("skip_all_flag", 32'(out_data_flag), 1);
        check("skip_all_en", 32'(stage_en), 0);
        check("skip_all_busy", 32'(busy), 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        calc_en   = 1'b0;
        check("skip_all_done", 32'(done), 1);
        cyc();
        // watchdog on stage 1
        frame_num  = 8'd0;
        stage_skip = 3'b000;
        tmo_limit  = 16'd8;
        calc_en    = 1'b1;
        cyc();
        check("t4_en0", 32'(stage_en), 32'b001);
        fin_stage(0, 1);
        check("t4_en1", 32'(stage_en), 32'b010);
        for (int i = 1; i < 8; i++) begin
            cyc();
            check("t4_wait", 32'(stage_en), 32'b010);
            check("t4_no_tmo", 32'(tmo_err), 0);
        end
        cyc();
        check("t4_tmo", 32'(tmo_err), 1);
        check("t4_err_stage", 32'(err_stage), 1);
        check("t4_en_off", 32'(stage_en), 0);
        check("t4_busy", 32'(busy), 0);
        cyc();
        check("t4_tmo_hold", 32'(tmo_err), 1);
        calc_en = 1'b0;
        cyc();
        check("t4_tmo_clr", 32'(tmo_err), 0);
        // fin on the last allowed cycle beats the timeout; then abort beats fin
        stage_skip = 3'b110;
        calc_en    = 1'b1;
        cyc();
        check("t5_en0", 32'(stage_en), 32'b001);
        fin_stage(0, 7);
        check("t5_fin_wins_tmo", 32'(tmo_err), 0);
        check("t5_flag", 32'(out_data_flag), 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("t5_loop_en", 32'(stage_en), 32'b001);
        check("t5_fcnt1", 32'(frame_cnt), 1);
        calc_en   = 1'b0;
        stage_fin = 3'b001;
        cyc();
        stage_fin = '0;
        check("t5_abort_en", 32'(stage_en), 0);
        check("t5_abort_flag", 32'(out_data_flag), 0);
        check("t5_abort_busy", 32'(busy), 0);
        check("t5_abort_fcnt", 32'(frame_cnt), 0);
        // asynchronous reset in the middle of stage 1
        tmo_limit  = 16'd0;
        stage_skip = 3'b000;
        calc_en    = 1'b1;
        cyc();
        fin_stage(0, 1);
        check("t6_en1", 32'(stage_en), 32'b010);
        #2;
        rst_n   = 1'b0;
        calc_en = 1'b0;
        #1;
        check_zero("t6_async");
        cyc();
        rst_n = 1'b1;
        cyc();
        check("t6_idle", 32'(stage_en), 0);
        calc_en = 1'b1;
        cyc();
        check("t6_restart", 32'(stage_en), 32'b001);
        check("t6_restart_busy", 32'(busy), 1);
        calc_en = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
